// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core: captures decoded
// operands/control, resolves EX/MEM and MEM/WB forwarding, and bubbles on load-use.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [SEL_W-1:0] id_alu_sel,
  input  logic             id_src_a_pc,
  input  logic             id_src_b_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             load_use,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_rs2_fwd,
  output logic [RA_W-1:0]  ex_rd,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg
);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [RA_W-1:0]  r_rs1;
  logic [RA_W-1:0]  r_rs2;
  logic [RA_W-1:0]  r_rd;
  logic [SEL_W-1:0] r_alu_sel;
  logic             r_src_a_pc;
  logic             r_src_b_imm;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_mem_to_reg;

  logic             w_load_use;
  logic             w_bubble;
  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;

  // Only registered state and ID inputs feed this, so stall/flush cannot loop back.
  assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));
  assign w_bubble   = flush | (~stall & w_load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_sel    <= '0;
      r_src_a_pc   <= 1'b0;
      r_src_b_imm  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_sel    <= '0;
      r_src_a_pc   <= 1'b0;
      r_src_b_imm  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_pc         <= id_pc;
      r_imm        <= id_imm;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_alu_sel    <= id_alu_sel;
      r_src_a_pc   <= id_src_a_pc;
      r_src_b_imm  <= id_src_b_imm;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_mem_to_reg <= id_mem_to_reg;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs1))
      w_fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs1))
      w_fwd_rs1 = memwb_result;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs2))
      w_fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs2))
      w_fwd_rs2 = memwb_result;
  end

  assign load_use      = w_load_use;
  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_imm        = r_imm;
  assign ex_rs2_fwd    = w_fwd_rs2;
  assign ex_rd         = r_rd;
  assign alu_a         = r_src_a_pc  ? r_pc  : w_fwd_rs1;
  assign alu_b         = r_src_b_imm ? r_imm : w_fwd_rs2;
  assign alu_sel       = r_alu_sel;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule
